// File: rtl/serial_pal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pal_pkg
//  Description : Shared defaults and the shift-direction encoding for the
//                serial-to-parallel converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pal_pkg;

   // Default parallel width and bit ordering used when the top is not
   // overridden.
   localparam int unsigned DEFAULT_WIDTH     = 4;
   localparam bit          DEFAULT_MSB_FIRST = 1'b1;

   // Direction in which older samples travel through the shift register.
   typedef enum logic {
      SHIFT_TOWARD_LSB = 1'b0,   // new bit enters at WIDTH-1
      SHIFT_TOWARD_MSB = 1'b1    // new bit enters at bit 0
   } shift_dir_e;

endpackage : serial_pal_pkg
`default_nettype wire

// File: rtl/serial_pal.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pal
//  Description : Serial-to-parallel converter. Shifts one serial bit into a
//                WIDTH-bit register on every enabled rising edge; the register
//                drives the parallel output directly, so out is a sliding
//                window of the last WIDTH enabled samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pal
   import serial_pal_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,     // must be >= 2
   parameter bit          MSB_FIRST = DEFAULT_MSB_FIRST
) (
   output logic [WIDTH-1:0] out,
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in
);

   localparam logic [WIDTH-1:0] c_RESET_VAL = '0;
   localparam shift_dir_e       c_DIR       = MSB_FIRST ? SHIFT_TOWARD_MSB
                                                        : SHIFT_TOWARD_LSB;

   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_next;

   // Next register value when enabled; direction is fixed at elaboration.
   generate
      if (c_DIR == SHIFT_TOWARD_MSB) begin : g_msb_first
         assign w_shift_next = {r_shift[WIDTH-2:0], in};
      end else begin : g_lsb_first
         assign w_shift_next = {in, r_shift[WIDTH-1:1]};
      end
   endgenerate

   // Shift register: reset clears, enable shifts, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift <= c_RESET_VAL;
      end else if (en) begin
         r_shift <= w_shift_next;
      end
   end

   // Parallel word comes straight from the register (no combinational path).
   assign out = r_shift;

endmodule : serial_pal
`default_nettype wire

// File: tb/tb_serial_pal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_pal
//  Description : Self-checking bench for serial_pal. Three instances (4-bit
//                MSB-first, 4-bit LSB-first, 8-bit MSB-first) share one
//                stimulus stream; a sample-history model predicts each word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pal;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       in;
   logic [3:0] out_a;
   logic [3:0] out_b;
   logic [7:0] out_c;

   always #5 clk = ~clk;

   serial_pal #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
      .out(out_a), .clk(clk), .reset(reset), .en(en), .in(in));
   serial_pal #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (
      .out(out_b), .clk(clk), .reset(reset), .en(en), .in(in));
   serial_pal #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (
      .out(out_c), .clk(clk), .reset(reset), .en(en), .in(in));

   typedef struct {
      int         idx;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] c;
   } exp_t;

   exp_t sb[$];
   bit   hist[$];      // enabled samples, newest at index 0
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_idx = 0;

   // Word seen by a register of width w: the last w enabled samples, placed
   // newest-at-bit-0 (MSB-first) or newest-at-top (LSB-first).
   function automatic logic [7:0] window(int w, bit msb_first);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         if (msb_first) r[i]       = hist[i];
         else           r[w-1-i]   = hist[i];
      end
      return r;
   endfunction

   // Drive one cycle of stimulus and queue the expected post-edge words.
   task automatic step(input bit r, input bit e, input bit b);
      exp_t x;
      @(negedge clk);
      reset = r;
      en    = e;
      in    = b;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 8; i++) hist[i] = 1'b0;
      end else if (e) begin
         hist.push_front(b);
         hist.delete(8);
      end
      step_idx++;
      x.idx = step_idx;
      x.a   = window(4, 1'b1)[3:0];
      x.b   = window(4, 1'b0)[3:0];
      x.c   = window(8, 1'b1);
      sb.push_back(x);
   endtask

   // Monitor: compare each queued expectation half a cycle after its edge.
   exp_t m;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m = sb.pop_front();
         n_checks++;
         if (out_a === m.a) n_pass++;
         else $display("FAIL msb4 step %0d: got %b expected %b", m.idx, out_a, m.a);
         n_checks++;
         if (out_b === m.b) n_pass++;
         else $display("FAIL lsb4 step %0d: got %b expected %b", m.idx, out_b, m.b);
         n_checks++;
         if (out_c === m.c) n_pass++;
         else $display("FAIL msb8 step %0d: got %b expected %b", m.idx, out_c, m.c);
      end
   end

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      in    = 1'b0;
      for (int i = 0; i < 8; i++) hist.push_back(1'b0);

      // Reset dominates en/in for three edges, then idle with en=0.
      repeat (3) step(1'b1, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b1);
      // Basic shift 1,0,1,1.
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      // Hold for five edges while in toggles, then resume with 0.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, i[0]);
      step(1'b0, 1'b1, 1'b0);
      // Mid-stream reset with en=1, then a 1.
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      // Sliding window of constant ones from reset.
      step(1'b1, 1'b0, 1'b0);
      repeat (10) step(1'b0, 1'b1, 1'b1);
      // LSB-first pattern 1,0,0,0 from reset.
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      // Randomized traffic with occasional resets and enable gaps.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0),
              ($urandom_range(0, 9) < 7),
              $urandom_range(0, 1) == 1);
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_serial_pal
`default_nettype wire
